// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter sharing one 4:1 data mux between four requesters and
//   a single downstream valid/ready consumer. Each grant is capped at
//   MAX_HOLD accepted transfers; every release is followed by one IDLE cycle.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req        per-requester data-available flags
//   in_data    packed requester data, requester i at [i*WIDTH +: WIDTH]
//   out_ready  downstream accepts a word this cycle
//   gnt        one-hot grant, zero when idle
//   sel1/sel0  registered mux select (granted index)
//   out_valid  out_data carries a valid word
//   out_data   data slice selected by {sel1,sel0}
//   busy       high while a grant is active
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic               out_ready,
  output logic [3:0]         gnt,
  output logic               sel0,
  output logic               sel1,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic       xfer;
  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  // Only the granted requester's flag can assert out_valid.
  always_comb begin
    out_valid = (state_q == GRANT) && req[sel_q];
    xfer      = out_valid && out_ready;
  end

  always_comb begin
    out_data = '0;
    case (sel_q)
      2'd0:    out_data = in_data[0*WIDTH +: WIDTH];
      2'd1:    out_data = in_data[1*WIDTH +: WIDTH];
      2'd2:    out_data = in_data[2*WIDTH +: WIDTH];
      default: out_data = in_data[3*WIDTH +: WIDTH];
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    found   = 1'b0;
    pick    = '0;
    cand    = '0;
    case (state_q)
      IDLE: begin
        // Search ptr, ptr+1, ... with natural 2-bit wrap; first hit wins.
        for (int unsigned k = 0; k < 4; k++) begin
          cand = ptr_q + 2'(k);
          if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
          end
        end
        if (found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          hold_d  = '0;
        end
      end
      default: begin
        // A dropped request releases without a transfer; the last allowed
        // transfer releases on the same edge it is accepted.
        if (!req[sel_q] || (xfer && hold_q == HOLD_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
          hold_d  = '0;
        end else if (xfer) begin
          hold_d = hold_q + 4'd1;
        end
      end
    endcase
  end

  assign gnt  = gnt_q;
  assign sel0 = sel_q[0];
  assign sel1 = sel_q[1];
  assign busy = (state_q == GRANT);

endmodule
